// File: rtl/cache_pkg.sv
// Shared cache geometry, address split/join helpers and miss-FSM state encoding.
// Used by the dcache today and intended for the icache as well.
package cache_pkg;

  localparam int unsigned SETS       = 256;
  localparam int unsigned LINE_WORDS = 4;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned BE_W       = WORD_W / 8;
  localparam int unsigned OFF_W      = $clog2(LINE_WORDS);
  localparam int unsigned IDX_W      = $clog2(SETS);
  localparam int unsigned TAG_W      = ADDR_W - IDX_W - OFF_W - 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EVICT  = 2'd1,
    REFILL = 2'd2
  } cache_state_e;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic [OFF_W-1:0] off;
    logic [1:0]       byte_sel;
  } cache_addr_t;

  function automatic cache_addr_t split_addr(input logic [ADDR_W-1:0] addr);
    return cache_addr_t'(addr);
  endfunction

  function automatic logic [ADDR_W-1:0] join_addr(input logic [TAG_W-1:0] tag,
                                                  input logic [IDX_W-1:0] idx,
                                                  input logic [OFF_W-1:0] off);
    return {tag, idx, off, 2'b00};
  endfunction

endpackage

// File: rtl/dcache_ctrl_if.sv
// Word-serial backing-memory bus between the dcache controller and memory.
// Controller is the master; the memory side is the slave.
interface dcache_ctrl_if;
  import cache_pkg::*;

  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [WORD_W-1:0] mem_wdata_o;
  logic              mem_ready_i;
  logic              mem_rvalid_i;
  logic [WORD_W-1:0] mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_ready_i, mem_rvalid_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_ready_i, mem_rvalid_i, mem_rdata_i
  );

endinterface

// File: rtl/dcache_data_array.sv
// Line storage: two async read ports (load word, eviction word) on one set,
// one byte-enable write port shared by store hits and refill beats.
module dcache_data_array
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [OFF_W-1:0]  rd_off,
  output logic [WORD_W-1:0] rd_data_c,
  input  logic [OFF_W-1:0]  ev_off,
  output logic [WORD_W-1:0] ev_data_c,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [OFF_W-1:0]  wr_off,
  input  logic [BE_W-1:0]   wr_be,
  input  logic [WORD_W-1:0] wr_data
);

  logic [WORD_W-1:0] words [SETS][LINE_WORDS];

  assign rd_data_c = words[rd_idx][rd_off];
  assign ev_data_c = words[rd_idx][ev_off];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < int'(BE_W); b++) begin
        if (wr_be[b]) words[wr_idx][wr_off][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate dcache controller for the M stage.
// Misses run evict-then-refill over a word-serial bus while CacheStall freezes the pipe.
module dcache_ctrl
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MemReadM,
  input  logic              MemWriteM,
  input  logic [ADDR_W-1:0] AddrM,
  input  logic [WORD_W-1:0] WriteDataM,
  input  logic [BE_W-1:0]   ByteEnM,
  output logic [WORD_W-1:0] ReadDataM,
  output logic              CacheStall,
  dcache_ctrl_if.master     mem
);

  cache_state_e      state, next_state;
  logic [OFF_W-1:0]  cnt;
  logic              waiting;
  logic [SETS-1:0]   valid, dirty;
  logic [TAG_W-1:0]  tags [SETS];

  cache_addr_t       a;
  logic              unused_byte_sel_c;
  logic              access, hit, miss, store_hit, accept, last;
  logic              beat, line_done, evict_done, refill_start;
  logic [WORD_W-1:0] rd_word, ev_word;
  logic              arr_we;
  logic [OFF_W-1:0]  arr_off;
  logic [BE_W-1:0]   arr_be;
  logic [WORD_W-1:0] arr_wdata;

  assign a                 = split_addr(AddrM);
  assign unused_byte_sel_c = ^a.byte_sel;

  assign access       = MemReadM | MemWriteM;
  assign hit          = valid[a.idx] & (tags[a.idx] == a.tag);
  assign miss         = access & ~hit;
  assign store_hit    = (state == IDLE) & hit & MemWriteM;
  assign accept       = mem.mem_req_o & mem.mem_ready_i;
  assign last         = (cnt == OFF_W'(LINE_WORDS - 1));
  assign beat         = (state == REFILL) & waiting & mem.mem_rvalid_i;
  assign line_done    = beat & last;
  assign evict_done   = (state == EVICT) & accept & last;
  assign refill_start = (state != REFILL) & (next_state == REFILL);

  // Refill beats own the write port; otherwise it carries store hits.
  assign arr_we    = store_hit | beat;
  assign arr_off   = beat ? cnt : a.off;
  assign arr_be    = beat ? {BE_W{1'b1}} : ByteEnM;
  assign arr_wdata = beat ? mem.mem_rdata_i : WriteDataM;

  dcache_data_array u_data (
    .clk       (clk),
    .rd_idx    (a.idx),
    .rd_off    (a.off),
    .rd_data_c (rd_word),
    .ev_off    (cnt),
    .ev_data_c (ev_word),
    .wr_en     (arr_we),
    .wr_idx    (a.idx),
    .wr_off    (arr_off),
    .wr_be     (arr_be),
    .wr_data   (arr_wdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (miss) next_state = (valid[a.idx] & dirty[a.idx]) ? EVICT : REFILL;
      EVICT:   if (evict_done) next_state = REFILL;
      REFILL:  if (line_done) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    CacheStall      = 1'b0;
    ReadDataM       = '0;
    mem.mem_req_o   = 1'b0;
    mem.mem_we_o    = 1'b0;
    mem.mem_addr_o  = '0;
    mem.mem_wdata_o = '0;
    CacheStall = access & ~((state == IDLE) & hit);
    if ((state == IDLE) & hit & MemReadM & ~MemWriteM) ReadDataM = rd_word;
    case (state)
      EVICT: begin
        mem.mem_req_o   = 1'b1;
        mem.mem_we_o    = 1'b1;
        mem.mem_addr_o  = join_addr(tags[a.idx], a.idx, cnt);
        mem.mem_wdata_o = ev_word;
      end
      REFILL: begin
        mem.mem_req_o  = ~waiting;
        mem.mem_addr_o = join_addr(a.tag, a.idx, cnt);
      end
      default: ;
    endcase
  end

  // Valid drops when a refill begins so a partially written line never hits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      waiting <= 1'b0;
      valid   <= '0;
      dirty   <= '0;
    end else begin
      if (((state == EVICT) & accept) | beat) cnt <= cnt + OFF_W'(1);
      if ((state == REFILL) & accept) waiting <= 1'b1;
      else if (beat)                  waiting <= 1'b0;
      if (refill_start)               valid[a.idx] <= 1'b0;
      if (line_done)                  valid[a.idx] <= 1'b1;
      if (store_hit)                  dirty[a.idx] <= 1'b1;
      if (evict_done | line_done)     dirty[a.idx] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (line_done) tags[a.idx] <= a.tag;
  end

  a_inputs_held: assert property (@(posedge clk) disable iff (!rst_n)
    (state != IDLE) |-> ($stable(AddrM) && $stable(MemReadM) && $stable(MemWriteM) &&
                         $stable(WriteDataM) && $stable(ByteEnM)));

endmodule
